// File: rtl/firebird7_in_gate2_ijtag_drv_pkg.sv
// firebird7_in_gate2_ijtag_drv_pkg: shared types for the IJTAG scan driver.
// State encoding, default scan length and a state-class helper.
package firebird7_in_gate2_ijtag_drv_pkg;

  localparam int DRV_MAX_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE,
    ST_DONE
  } drv_state_e;

  function automatic logic drv_active(input drv_state_e s);
    return (s == ST_CAPTURE) || (s == ST_SHIFT) || (s == ST_UPDATE);
  endfunction

endpackage

// File: rtl/firebird7_in_gate2_ijtag_scan_driver_if.sv
// firebird7_in_gate2_ijtag_scan_driver_if: command/response bundle.
// Master issues scan commands and consumes responses; slave is the driver.
interface firebird7_in_gate2_ijtag_scan_driver_if
  import firebird7_in_gate2_ijtag_drv_pkg::*;
#(
  parameter int MAX_LEN = DRV_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CNT_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               cmd_capture;
  logic               cmd_update;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_len, cmd_data,
    output cmd_capture, cmd_update, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_data,
    input  cmd_capture, cmd_update, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/firebird7_in_gate2_ijtag_drv_shreg.sv
// firebird7_in_gate2_ijtag_drv_shreg: tx/rx scan data registers.
// tx shifts out LSB first; rx collects returned bits by shift index.
module firebird7_in_gate2_ijtag_drv_shreg
  import firebird7_in_gate2_ijtag_drv_pkg::*;
#(
  parameter int MAX_LEN = DRV_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [CNT_W-1:0]   rx_idx,
  input  logic               rx_bit,
  output logic               tx_bit0,
  output logic               tx_bit1,
  output logic [MAX_LEN-1:0] rx_data
);
  logic [MAX_LEN-1:0] tx_q, tx_d;
  logic [MAX_LEN-1:0] rx_q, rx_d;

  // Load clears rx so unshifted positions read back as zero.
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load) begin
      tx_d = load_data;
      rx_d = '0;
    end else if (shift) begin
      tx_d = tx_q >> 1;
      rx_d = rx_q | ({{(MAX_LEN-1){1'b0}}, rx_bit} << rx_idx);
    end
  end

  // Data registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign tx_bit0 = tx_q[0];
  assign tx_bit1 = tx_q[1];
  assign rx_data = rx_q;
endmodule

// File: rtl/firebird7_in_gate2_ijtag_scan_driver.sv
// firebird7_in_gate2_ijtag_scan_driver: capture/shift/update sequencer.
// Define FIREBIRD7_IJTAG_DRV_ABORT_EN to add the cmd_abort input.
module firebird7_in_gate2_ijtag_scan_driver
  import firebird7_in_gate2_ijtag_drv_pkg::*;
#(
  parameter int MAX_LEN = DRV_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               cmd_capture,
  input  logic               cmd_update,
`ifdef FIREBIRD7_IJTAG_DRV_ABORT_EN
  input  logic               cmd_abort,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               ijtag_sel,
  output logic               ijtag_si,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  input  logic               ijtag_from_so
);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d, len_in;
  logic             upd_q, upd_d;
  logic             sel_q, si_q, ce_q, se_q, ue_q, rv_q;
  logic             sel_d, si_d, ce_d, se_d, ue_d, rv_d;
  logic             load, shift, tx_bit0, tx_bit1;

  assign len_in = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  // Next state, datapath controls and next registered outputs.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    upd_d   = upd_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          load  = 1'b1;
          len_d = len_in;
          upd_d = cmd_update;
          cnt_d = '0;
          if (cmd_capture)       state_d = ST_CAPTURE;
          else if (len_in != '0) state_d = ST_SHIFT;
          else if (cmd_update)   state_d = ST_UPDATE;
          else                   state_d = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        if (len_q != '0) state_d = ST_SHIFT;
        else if (upd_q)  state_d = ST_UPDATE;
        else             state_d = ST_DONE;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + ONE;
        if (cnt_q == len_q - ONE)
          state_d = upd_q ? ST_UPDATE : ST_DONE;
      end
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
`ifdef FIREBIRD7_IJTAG_DRV_ABORT_EN
    if (cmd_abort && drv_active(state_q)) begin
      state_d = ST_IDLE;
      shift   = 1'b0;
    end
`endif
    sel_d = drv_active(state_d);
    ce_d  = (state_d == ST_CAPTURE);
    se_d  = (state_d == ST_SHIFT);
    ue_d  = (state_d == ST_UPDATE);
    rv_d  = (state_d == ST_DONE);
    si_d  = 1'b0;
    if (se_d) begin
      if (load)       si_d = cmd_data[0];
      else if (shift) si_d = tx_bit1;
      else            si_d = tx_bit0;
    end
  end

  // State, command fields and registered network controls.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      si_q    <= 1'b0;
      ce_q    <= 1'b0;
      se_q    <= 1'b0;
      ue_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      si_q    <= si_d;
      ce_q    <= ce_d;
      se_q    <= se_d;
      ue_q    <= ue_d;
      rv_q    <= rv_d;
    end
  end

  firebird7_in_gate2_ijtag_drv_shreg #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_shreg (
    .clk       (ijtag_tck),
    .rst       (ijtag_reset),
    .load      (load),
    .shift     (shift),
    .load_data (cmd_data),
    .rx_idx    (cnt_q),
    .rx_bit    (ijtag_from_so),
    .tx_bit0   (tx_bit0),
    .tx_bit1   (tx_bit1),
    .rx_data   (rsp_data)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rv_q;
  assign ijtag_sel = sel_q;
  assign ijtag_si  = si_q;
  assign ijtag_ce  = ce_q;
  assign ijtag_se  = se_q;
  assign ijtag_ue  = ue_q;
endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_scan_driver.sv
// tb_firebird7_in_gate2_ijtag_scan_driver: directed scan command bench.
// Drives a shift-register network model behind the driver.
module tb_firebird7_in_gate2_ijtag_scan_driver;
  localparam int ML = 64;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic sel, si, ce, se, ue, so;
  logic [ML-1:0] net, pre_val;
  logic pre_req;
  int net_len;
  int n_chk = 0;
  int n_pass = 0;

  firebird7_in_gate2_ijtag_scan_driver_if #(.MAX_LEN(ML), .CNT_W(CW)) bus();

  firebird7_in_gate2_ijtag_scan_driver #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .ijtag_tck     (clk),
    .ijtag_reset   (rst),
    .cmd_valid     (bus.cmd_valid),
    .cmd_ready     (bus.cmd_ready),
    .cmd_len       (bus.cmd_len),
    .cmd_data      (bus.cmd_data),
    .cmd_capture   (bus.cmd_capture),
    .cmd_update    (bus.cmd_update),
`ifdef FIREBIRD7_IJTAG_DRV_ABORT_EN
    .cmd_abort     (abort),
`endif
    .rsp_valid     (bus.rsp_valid),
    .rsp_ready     (bus.rsp_ready),
    .rsp_data      (bus.rsp_data),
    .ijtag_sel     (sel),
    .ijtag_si      (si),
    .ijtag_ce      (ce),
    .ijtag_se      (se),
    .ijtag_ue      (ue),
    .ijtag_from_so (so)
  );

  always #5 clk = ~clk;

  assign so = net[0];

  always @(posedge clk) begin
    if (pre_req)
      net <= pre_val;
    else if (sel && se)
      net <= (net >> 1) | ({{(ML-1){1'b0}}, si} << (net_len - 1));
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input logic [ML-1:0] v, input int len);
    @(negedge clk);
    pre_val = v;
    net_len = len;
    pre_req = 1'b1;
    @(posedge clk);
    #1 pre_req = 1'b0;
  endtask

  task automatic run_cmd(input logic [CW-1:0] len, input logic [ML-1:0] data,
                         input logic cap, input logic upd,
                         output int ncyc, output int nce, output int nse,
                         output int nue, output int nsel,
                         output logic [ML-1:0] si_bits, output int bad);
    logic seen, ended;
    ncyc = -1; nce = 0; nse = 0; nue = 0; nsel = 0;
    si_bits = '0; bad = 0; seen = 1'b0; ended = 1'b0;
    @(negedge clk);
    if (!bus.cmd_ready) bad++;
    bus.cmd_len = len;
    bus.cmd_data = data;
    bus.cmd_capture = cap;
    bus.cmd_update = upd;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ce) nce++;
      if (se) begin
        if (nse < ML) si_bits[nse[5:0]] = si;
        nse++;
      end
      if (ue) nue++;
      if (sel) nsel++;
      if (int'(ce) + int'(se) + int'(ue) > 1) bad++;
      if ((ce || se || ue) && !sel) bad++;
      if (!se && si) bad++;
      if (sel && ended) bad++;
      if (bus.cmd_ready) bad++;
      if (sel) seen = 1'b1;
      else if (seen) ended = 1'b1;
      if (bus.rsp_valid) begin
        ncyc = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", {63'b0, bus.cmd_ready}, 64'd1);
  endtask

  int ncyc, nce, nse, nue, nsel, bad;
  logic [ML-1:0] sib;
  logic ok;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; abort = 1'b0; pre_req = 1'b0; pre_val = '0;
    net_len = 8;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_data = '0;
    bus.cmd_capture = 1'b0; bus.cmd_update = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_ijtag", {59'b0, sel, si, ce, se, ue}, 64'd0);
    rst = 1'b0;

    preload(64'h3C, 8);
    run_cmd(7'd8, 64'hA5, 1'b1, 1'b1, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s1_cycles", ncyc, 64'd11);
    chk("s1_ce", nce, 64'd1);
    chk("s1_se", nse, 64'd8);
    chk("s1_ue", nue, 64'd1);
    chk("s1_sel", nsel, 64'd10);
    chk("s1_si", sib, 64'hA5);
    chk("s1_proto", bad, 64'd0);
    chk("s1_rsp", bus.rsp_data, 64'h3C);
    chk("s1_net", net, 64'hA5);
    consume();

    preload(64'hFF, 8);
    run_cmd(7'd5, 64'h1B, 1'b0, 1'b1, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s2_cycles", ncyc, 64'd7);
    chk("s2_se", nse, 64'd5);
    chk("s2_si", sib, 64'h1B);
    chk("s2_rsp_mask", bus.rsp_data, 64'h1F);
    chk("s2_proto", bad, 64'd0);
    consume();

    run_cmd(7'd0, 64'hFFFF, 1'b0, 1'b0, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s3_cycles", ncyc, 64'd1);
    chk("s3_sel", nsel, 64'd0);
    chk("s3_rsp", bus.rsp_data, 64'd0);
    consume();

    run_cmd(7'd0, 64'h0, 1'b1, 1'b1, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s4_cycles", ncyc, 64'd3);
    chk("s4_ce_ue", {nce[31:0], nue[31:0]}, {32'd1, 32'd1});
    chk("s4_sel", nsel, 64'd2);
    chk("s4_proto", bad, 64'd0);
    consume();

    preload(64'h6, 4);
    run_cmd(7'd4, 64'h9, 1'b0, 1'b0, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s5_cycles", ncyc, 64'd5);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 64'h6 || bus.cmd_ready ||
          sel || si || ce || se || ue) ok = 1'b0;
    end
    chk("s5_hold", {63'b0, ok}, 64'd1);
    chk("s5_rsp", bus.rsp_data, 64'h6);
    consume();

    preload(64'h1234, 16);
    @(negedge clk);
    bus.cmd_len = 7'd16; bus.cmd_data = 64'hFFFF;
    bus.cmd_capture = 1'b0; bus.cmd_update = 1'b1; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("s6_in_shift", {63'b0, se}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s6_ijtag", {59'b0, sel, si, ce, se, ue}, 64'd0);
    chk("s6_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("s6_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid || sel) ok = 1'b0;
    end
    chk("s6_discard", {63'b0, ok}, 64'd1);
    preload(64'h5A, 8);
    run_cmd(7'd8, 64'hC3, 1'b1, 1'b0, ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s6_re_cycles", ncyc, 64'd10);
    chk("s6_re_si", sib, 64'hC3);
    chk("s6_re_rsp", bus.rsp_data, 64'h5A);
    chk("s6_re_proto", bad, 64'd0);
    consume();

    preload(64'hDEADBEEF0BADF00D, 64);
    run_cmd(7'd69, 64'h0123456789ABCDEF, 1'b0, 1'b0,
            ncyc, nce, nse, nue, nsel, sib, bad);
    chk("s7_se", nse, 64'd64);
    chk("s7_cycles", ncyc, 64'd65);
    chk("s7_si", sib, 64'h0123456789ABCDEF);
    chk("s7_rsp", bus.rsp_data, 64'hDEADBEEF0BADF00D);
    consume();

`ifdef FIREBIRD7_IJTAG_DRV_ABORT_EN
    preload(64'h0, 16);
    @(negedge clk);
    bus.cmd_len = 7'd16; bus.cmd_data = 64'h5555;
    bus.cmd_capture = 1'b0; bus.cmd_update = 1'b1; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_in_shift", {63'b0, se}, 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("ab_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    chk("ab_ijtag", {59'b0, sel, si, ce, se, ue}, 64'd0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid || sel) ok = 1'b0;
    end
    chk("ab_no_rsp", {63'b0, ok}, 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
